// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 Booth multiplier.
package booth_pkg;

    typedef struct packed {
        logic zero;
        logic one;
        logic double;
        logic negate;
    } booth_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra digit beyond WIDTH/2 so unsigned operands with the top bit set recode correctly.
    function automatic int num_digits(input int width);
        return width / 2 + 1;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width / 2 + 2);
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window to {0, +-A, +-2A}.
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0]   win,
    output booth_digit_t digit
);

    always_comb begin
        digit = '0;
        case (win)
            3'b001, 3'b010: digit.one = 1'b1;
            3'b011:         digit.double = 1'b1;
            3'b100:         begin digit.double = 1'b1; digit.negate = 1'b1; end
            3'b101, 3'b110: begin digit.one = 1'b1; digit.negate = 1'b1; end
            default:        digit.zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier, one digit per clock through a single shared adder.
// Optional macro BOOTH_MUL_EARLY_EXIT_EN finishes as soon as all remaining digits are zero.
module booth_mul_iter
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product
);

    localparam int N  = num_digits(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam int MW = WIDTH + 3;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [MW-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    booth_digit_t    digit;
    logic            neg;
    logic [PW-1:0]   pp, sum;
    logic [MW-1:0]   mplier_sh;
    logic            last_digit;
    logic            a_ext, b_ext;

    booth_digit_enc u_enc (
        .win   (mplier_q[2:0]),
        .digit (digit)
    );

    assign a_ext = in_signed & in_a[WIDTH-1];
    assign b_ext = in_signed & in_b[WIDTH-1];

    // Negation is folded into the adder as invert plus carry-in.
    always_comb begin
        pp = '0;
        if (digit.one)    pp = mcand_q;
        if (digit.double) pp = {mcand_q[PW-2:0], 1'b0};
        neg       = digit.negate & ~digit.zero;
        sum       = acc_q + (pp ^ {PW{neg}}) + {{(PW-1){1'b0}}, neg};
        mplier_sh = {{2{mplier_q[MW-1]}}, mplier_q[MW-1:2]};
`ifdef BOOTH_MUL_EARLY_EXIT_EN
        last_digit = (cnt_q == LAST_CNT) || (&mplier_sh) || ~(|mplier_sh);
`else
        last_digit = (cnt_q == LAST_CNT);
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = BUSY;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{a_ext}}, in_a};
                    mplier_d = {b_ext, b_ext, in_b, 1'b0};
                    cnt_d    = '0;
                end
            end
            BUSY: begin
                acc_d    = sum;
                mcand_d  = {mcand_q[PW-3:0], 2'b00};
                mplier_d = mplier_sh;
                cnt_d    = cnt_q + 1'b1;
                if (last_digit) begin
                    state_d = DONE;
                    prod_d  = sum;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_product = prod_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Scoreboard bench for booth_mul_iter: directed corners on WIDTH=32, random streams on WIDTH 32/8/4.
module tb_booth_mul_iter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  iv, ir, ov;
    logic        isg, ordy;
    logic [31:0] ia, ib;
    logic [63:0] p32;
    logic [15:0] p8;
    logic [7:0]  p4;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          sel = 0;
    logic        cur_ready, cur_valid;
    logic [63:0] cur_prod;
    logic [63:0] sb[$];

    booth_mul_iter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_signed(isg),
        .in_a(ia), .in_b(ib), .out_valid(ov[0]), .out_ready(ordy), .out_product(p32));
    booth_mul_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_signed(isg),
        .in_a(ia[7:0]), .in_b(ib[7:0]), .out_valid(ov[1]), .out_ready(ordy), .out_product(p8));
    booth_mul_iter #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_signed(isg),
        .in_a(ia[3:0]), .in_b(ib[3:0]), .out_valid(ov[2]), .out_ready(ordy), .out_product(p4));

    always_comb begin
        case (sel)
            1:       begin cur_ready = ir[1]; cur_valid = ov[1]; cur_prod = {48'd0, p8}; end
            2:       begin cur_ready = ir[2]; cur_valid = ov[2]; cur_prod = {56'd0, p4}; end
            default: begin cur_ready = ir[0]; cur_valid = ov[0]; cur_prod = p32; end
        endcase
    end

    // Reference: extend both operands to 64 bits per signedness, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input bit s, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] m, ea, eb, pm;
        m  = (64'd1 << w) - 64'd1;
        ea = {32'd0, a} & m;
        eb = {32'd0, b} & m;
        if (s && ea[w-1]) ea = ea | ~m;
        if (s && eb[w-1]) eb = eb | ~m;
        pm = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        return (ea * eb) & pm;
    endfunction

    // Issues one operation on the selected DUT (assumed idle) and waits for out_valid.
    // lat is the cycle index of first out_valid, counting the accept cycle as 0.
    task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] prod, output int lat);
        isg = s; ia = a; ib = b; ordy = 1'b0;
        iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        lat = 1;
        while (!cur_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = cur_prod;
    endtask

    task automatic release_out();
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = '0; ordy = 1'b0; isg = 1'b0; ia = '0; ib = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total_cnt++;
        if (ir !== 3'b111) $display("FAIL reset_in_ready: got %b expected 111", ir);
        else pass_cnt++;
        total_cnt++;
        if (ov !== 3'b000) $display("FAIL reset_out_valid: got %b expected 000", ov);
        else pass_cnt++;
        total_cnt++;
        if (p32 !== 64'd0 || p8 !== 16'd0 || p4 !== 8'd0)
            $display("FAIL reset_product: got %h/%h/%h expected 0", p32, p8, p4);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        logic [63:0] prod;
        int          lat, exp_lat;
`ifdef BOOTH_MUL_EARLY_EXIT_EN
        exp_lat = 2;
`else
        exp_lat = 18;
`endif
        sel = 0;
        do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, prod, lat);
        total_cnt++;
        if (lat !== exp_lat) $display("FAIL latency_neg1: got %0d expected %0d", lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (prod !== 64'h1) $display("FAIL prod_neg1: got %h expected %h", prod, 64'h1);
        else pass_cnt++;
        release_out();
    endtask

    task automatic test_boundary();
        logic [63:0] prod;
        int          lat;
        sel = 0;
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, prod, lat);
        total_cnt++;
        if (prod !== 64'hFFFF_FFFE_0000_0001)
            $display("FAIL umax_sq: got %h expected %h", prod, 64'hFFFF_FFFE_0000_0001);
        else pass_cnt++;
        release_out();
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, prod, lat);
        total_cnt++;
        if (prod !== 64'h4000_0000_0000_0000)
            $display("FAIL smin_sq: got %h expected %h", prod, 64'h4000_0000_0000_0000);
        else pass_cnt++;
        release_out();
        do_op(1'b1, 32'h1234_5678, 32'h0, prod, lat);
        total_cnt++;
        if (prod !== 64'h0) $display("FAIL zero_b: got %h expected 0", prod);
        else pass_cnt++;
        release_out();
        do_op(1'b0, 32'h0, 32'hDEAD_BEEF, prod, lat);
        total_cnt++;
        if (prod !== 64'h0) $display("FAIL zero_a: got %h expected 0", prod);
        else pass_cnt++;
        release_out();
        do_op(1'b1, 32'h0000_0007, 32'h8000_0000, prod, lat);
        total_cnt++;
        if (prod !== 64'hFFFF_FFFC_8000_0000)
            $display("FAIL s7_min: got %h expected %h", prod, 64'hFFFF_FFFC_8000_0000);
        else pass_cnt++;
        release_out();
    endtask

    task automatic test_backpressure();
        logic [63:0] prod;
        int          lat;
        sel = 0;
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, prod, lat);
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || p32 !== 64'hFFFF_FFFE_0000_0001)
                $display("FAIL bp_hold[%0d]: got v=%b r=%b p=%h expected v=1 r=0 p=%h",
                         i, ov[0], ir[0], p32, 64'hFFFF_FFFE_0000_0001);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        release_out();
        total_cnt++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1)
            $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", ov[0], ir[0]);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [63:0] prod;
        int          lat;
        sel = 0;
        isg = 1'b1; ia = 32'h7654_3210; ib = 32'h0123_4567;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || p32 !== 64'd0)
            $display("FAIL abort_state: got r=%b v=%b p=%h expected r=1 v=0 p=0",
                     ir[0], ov[0], p32);
        else pass_cnt++;
        do_op(1'b1, 32'd3, 32'hFFFF_FFFB, prod, lat);
        total_cnt++;
        if (prod !== 64'hFFFF_FFFF_FFFF_FFF1)
            $display("FAIL abort_next_op: got %h expected %h", prod, 64'hFFFF_FFFF_FFFF_FFF1);
        else pass_cnt++;
        release_out();
    endtask

    task automatic test_early_exit();
        logic [63:0] prod, exp_p;
        int          lat;
        sel = 0;
        do_op(1'b1, 32'h1234_5678, 32'h0, prod, lat);
        total_cnt++;
`ifdef BOOTH_MUL_EARLY_EXIT_EN
        if (lat !== 2 || prod !== 64'h0)
            $display("FAIL ee_b0: got lat=%0d p=%h expected lat=2 p=0", lat, prod);
`else
        if (lat !== 18 || prod !== 64'h0)
            $display("FAIL ee_b0: got lat=%0d p=%h expected lat=18 p=0", lat, prod);
`endif
        else pass_cnt++;
        release_out();
        exp_p = ref_mul(32, 1'b1, 32'h0BAD_CAFE, 32'hFFFF_FFFF);
        do_op(1'b1, 32'h0BAD_CAFE, 32'hFFFF_FFFF, prod, lat);
        total_cnt++;
        if (prod !== exp_p) $display("FAIL ee_neg_a: got %h expected %h", prod, exp_p);
        else pass_cnt++;
        release_out();
        exp_p = ref_mul(32, 1'b0, 32'hCAFE_F00D, 32'h4000_0000);
        do_op(1'b0, 32'hCAFE_F00D, 32'h4000_0000, prod, lat);
        total_cnt++;
`ifdef BOOTH_MUL_EARLY_EXIT_EN
        if (lat <= 2 || lat >= 200 || prod !== exp_p)
            $display("FAIL ee_long: got lat=%0d p=%h expected lat>2 p=%h", lat, prod, exp_p);
`else
        if (lat !== 18 || prod !== exp_p)
            $display("FAIL ee_long: got lat=%0d p=%h expected lat=18 p=%h", lat, prod, exp_p);
`endif
        else pass_cnt++;
        release_out();
    endtask

    task automatic test_random(input int s_idx, input int nops);
        int w;
        sel = s_idx;
        w = (s_idx == 1) ? 8 : (s_idx == 2) ? 4 : 32;
        sb.delete();
        fork
            begin
                bit          got;
                int          k;
                logic [31:0] a, b;
                bit          s;
                for (int i = 0; i < nops; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                    s = 1'($urandom_range(0, 1));
                    a = $urandom;
                    b = $urandom;
                    case ($urandom_range(0, 7))
                        0: a = 32'hFFFF_FFFF;
                        1: b = 32'hFFFF_FFFF;
                        2: begin a = 32'h1 << (w - 1); b = 32'h1 << (w - 1); end
                        3: b = 32'h0;
                        default: ;
                    endcase
                    isg = s; ia = a; ib = b;
                    iv[sel] = 1'b1;
                    got = 1'b0;
                    k = 0;
                    do begin
                        @(negedge clk);
                        got = cur_ready;
                        if (got) sb.push_back(ref_mul(w, s, a, b));
                        @(posedge clk); #1;
                        k++;
                    end while (!got && k < 500);
                    iv[sel] = 1'b0;
                    if (!got) begin
                        total_cnt++;
                        $display("FAIL rand_accept_timeout w=%0d: got no in_ready expected accept", w);
                        break;
                    end
                end
            end
            begin
                int          rcv, cyc;
                logic [63:0] exp_p;
                rcv = 0;
                cyc = 0;
                while (rcv < nops && cyc < nops * 80 + 200) begin
                    ordy = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (cur_valid && ordy) begin
                        total_cnt++;
                        rcv++;
                        if (sb.size() == 0) begin
                            $display("FAIL rand_unexpected w=%0d: got %h expected none", w, cur_prod);
                        end else begin
                            exp_p = sb.pop_front();
                            if (cur_prod !== exp_p)
                                $display("FAIL rand_prod w=%0d: got %h expected %h", w, cur_prod, exp_p);
                            else pass_cnt++;
                        end
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                if (rcv < nops) begin
                    total_cnt++;
                    $display("FAIL rand_timeout w=%0d: got %0d results expected %0d", w, rcv, nops);
                end
            end
        join
        ordy = 1'b0;
        iv = '0;
        sel = 0;
    endtask

    initial begin
        rst = 1'b1; iv = '0; ordy = 1'b0; isg = 1'b0; ia = '0; ib = '0;
        test_reset();
        test_latency();
        test_boundary();
        test_backpressure();
        test_abort();
        test_early_exit();
        test_random(0, 1200);
        test_random(1, 2000);
        test_random(2, 2000);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
